// File: rtl/la_capture_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// la_capture_ctrl
// Trigger/capture sequencer for the logic-analyzer probe bus.
// The block keeps pre-trigger history in a circular sample RAM.
// It waits for a masked pattern match, records post-trigger samples,
// and then freezes the RAM for trigger-relative readback.
//
// Optional build macro:
//   LA_EDGE_TRIG_EN - trigger additionally requires that at least one masked
//                     bit changed versus the previous written sample.
// -----------------------------------------------------------------------------
module la_capture_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              abort,
  input  logic [DATA_W-1:0] probe,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [ADDR_W-1:0] pre_count,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        state,
  output logic              triggered,
  output logic              done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  // Registers
  state_t              state_r;
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]   pre_r;
  logic [ADDR_W-1:0]   post_eff_r;
  logic [DATA_W-1:0]   trig_value_r;
  logic [DATA_W-1:0]   trig_mask_r;
  logic [ADDR_W-1:0]   trig_addr_r;
  logic                triggered_r;
  logic                done_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  // Combinational signals
  state_t              state_s;
  logic [ADDR_W-1:0]   cnt_s;
  logic                wr_en_s;
  logic                load_cfg_s;
  logic                trig_cap_s;
  logic                match_s;
  logic                trig_hit_s;
  logic [ADDR_W-1:0]   pre_room_s;
  logic [ADDR_W-1:0]   post_clamp_s;
  logic [ADDR_W-1:0]   rd_idx_s;

  // Room left for post samples once the pre history is reserved (D-1-pre).
  assign pre_room_s   = ADDR_MAX - pre_count;
  assign post_clamp_s = (post_count > pre_room_s) ? pre_room_s : post_count;

  // The oldest kept sample sits pre_r entries before the trigger sample.
  assign rd_idx_s = trig_addr_r - pre_r + rd_addr;

  assign match_s = (((probe ^ trig_value_r) & trig_mask_r) == DATA_ZERO);

`ifdef LA_EDGE_TRIG_EN
  logic [DATA_W-1:0] prev_r;
  logic              prev_valid_r;
  logic              changed_s;

  assign changed_s  = prev_valid_r &&
                      (((probe ^ prev_r) & trig_mask_r) != DATA_ZERO);
  assign trig_hit_s = match_s && changed_s;

  // Track the previously written sample; the history starts fresh on each arm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r       <= DATA_ZERO;
      prev_valid_r <= 1'b0;
    end else if (load_cfg_s) begin
      prev_r       <= DATA_ZERO;
      prev_valid_r <= 1'b0;
    end else if (wr_en_s && (state_r == S_PRE || state_r == S_WAIT)) begin
      prev_r       <= probe;
      prev_valid_r <= 1'b1;
    end
  end
`else
  assign trig_hit_s = match_s;
`endif

  // Next-state logic: abort wins, arm is honoured only in IDLE/DONE.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    wr_en_s    = 1'b0;
    load_cfg_s = 1'b0;
    trig_cap_s = 1'b0;
    if (abort) begin
      state_s = S_IDLE;
      cnt_s   = ADDR_ZERO;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (arm) begin
            load_cfg_s = 1'b1;
            cnt_s      = ADDR_ZERO;
            if (pre_count == ADDR_ZERO) begin
              state_s = S_WAIT;
            end else begin
              state_s = S_PRE;
            end
          end else begin
            state_s = state_r;
          end
        end
        S_PRE: begin
          wr_en_s = 1'b1;
          if (cnt_r == (pre_r - ADDR_ONE)) begin
            cnt_s   = ADDR_ZERO;
            state_s = S_WAIT;
          end else begin
            cnt_s = cnt_r + ADDR_ONE;
          end
        end
        S_WAIT: begin
          wr_en_s = 1'b1;
          if (trig_hit_s) begin
            trig_cap_s = 1'b1;
            cnt_s      = ADDR_ZERO;
            if (post_eff_r != ADDR_ZERO) begin
              state_s = S_POST;
            end else begin
              state_s = S_DONE;
            end
          end else begin
            state_s = S_WAIT;
          end
        end
        S_POST: begin
          wr_en_s = 1'b1;
          if (cnt_r == (post_eff_r - ADDR_ONE)) begin
            cnt_s   = ADDR_ZERO;
            state_s = S_DONE;
          end else begin
            cnt_s = cnt_r + ADDR_ONE;
          end
        end
        default: begin
          state_s = S_IDLE;
          cnt_s   = ADDR_ZERO;
        end
      endcase
    end
  end

  // State, counters, captured configuration and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= ADDR_ZERO;
      wr_ptr_r     <= ADDR_ZERO;
      pre_r        <= ADDR_ZERO;
      post_eff_r   <= ADDR_ZERO;
      trig_value_r <= DATA_ZERO;
      trig_mask_r  <= DATA_ZERO;
      trig_addr_r  <= ADDR_ZERO;
      triggered_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      done_r  <= (state_s == S_DONE);
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_ONE;
      end
      if (load_cfg_s) begin
        pre_r        <= pre_count;
        post_eff_r   <= post_clamp_s;
        trig_value_r <= trig_value;
        trig_mask_r  <= trig_mask;
      end
      if (abort || load_cfg_s) begin
        triggered_r <= 1'b0;
      end else if (trig_cap_s) begin
        triggered_r <= 1'b1;
        trig_addr_r <= wr_ptr_r;
      end
    end
  end

  // Sample RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= probe;
    end
  end

  // Trigger-relative readback, updated only while the capture is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= DATA_ZERO;
    end else if (state_r == S_DONE) begin
      rd_data_r <= mem_r[rd_idx_s];
    end
  end

  assign rd_data   = rd_data_r;
  assign state     = state_r;
  assign triggered = triggered_r;
  assign done      = done_r;
  assign trig_addr = trig_addr_r;

endmodule

// File: tb/tb_la_capture_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_la_capture_ctrl
// Directed bench for la_capture_ctrl with hand-computed expectations.
// The probe can auto-increment each cycle to act as a free-running counter.
// -----------------------------------------------------------------------------
module tb_la_capture_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] probe;
  logic [DATA_W-1:0] trig_value;
  logic [DATA_W-1:0] trig_mask;
  logic [ADDR_W-1:0] pre_count;
  logic [ADDR_W-1:0] post_count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [2:0]        state;
  logic              triggered;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;

  int checks   = 0;
  int failures = 0;
  bit auto_inc = 1'b0;

  la_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .abort      (abort),
    .probe      (probe),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .pre_count  (pre_count),
    .post_count (post_count),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .state      (state),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr)
  );

  // 100 MHz sample clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_inc) probe = probe + 32'd1;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic read_at(input int idx, output logic [31:0] d);
    rd_addr = idx[ADDR_W-1:0];
    tick();
    d = rd_data;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] d;

    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; probe = 32'd0;
    trig_value = 32'd0; trig_mask = 32'd0;
    pre_count = 10'd0; post_count = 10'd0; rd_addr = 10'd0;
    #23;
    check("rst_state", 32'(state), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: counter probe, pre=4 post=3, trigger on 0x20
    probe = 32'h10; auto_inc = 1'b1;
    pre_count = 10'd4; post_count = 10'd3;
    trig_mask = 32'hFF; trig_value = 32'h20;
    arm_pulse();
    check("t1_state_pre", 32'(state), 32'd1);
    arm = 1'b1;              // ignored while capturing
    tick();
    arm = 1'b0;
    wait_done(100, n);
    check("t1_cycles", 32'(n), 32'd18);
    check("t1_state_done", 32'(state), 32'd4);
    check("t1_triggered", 32'(triggered), 32'd1);
    check("t1_trig_addr", 32'(trig_addr), 32'd15);
    for (int i = 0; i < 8; i++) begin
      read_at(i, d);
      check($sformatf("t1_rd%0d", i), d, 32'h1C + 32'(i));
    end

    // Test 2: mask=0, pre=0, post=0 -> single WAIT cycle
    probe = 32'hA5A5_0000;
    pre_count = 10'd0; post_count = 10'd0; trig_mask = 32'd0;
    arm_pulse();
    check("t2_state_wait", 32'(state), 32'd2);
    check("t2_trig_cleared", 32'(triggered), 32'd0);
    tick();
    check("t2_state_done", 32'(state), 32'd4);
    check("t2_trig_addr", 32'(trig_addr), 32'd19);
    read_at(0, d);
    check("t2_rd0", d, 32'hA5A5_0001);

    // Test 3: pre=D-1, post=5 clamps to 0
    probe = 32'h1000;
    pre_count = 10'd1023; post_count = 10'd5;
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'h1400;
    arm_pulse();
    wait_done(1100, n);
    check("t3_cycles", 32'(n), 32'd1024);
    check("t3_state_done", 32'(state), 32'd4);
    check("t3_trig_addr", 32'(trig_addr), 32'd19);
    read_at(1023, d);
    check("t3_rd_last", d, 32'h1400);
    read_at(0, d);
    check("t3_rd0", d, 32'h1001);

    // Test 4: abort together with arm while in POST
    pre_count = 10'd2; post_count = 10'd100; trig_mask = 32'd0;
    arm_pulse();
    tick();
    tick();
    tick();
    check("t4_state_post", 32'(state), 32'd3);
    check("t4_triggered", 32'(triggered), 32'd1);
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    check("t4_state_idle", 32'(state), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_triggered_clr", 32'(triggered), 32'd0);

    // Test 5: reset during WAIT, then a fresh capture
    probe = 32'h200;
    pre_count = 10'd0; post_count = 10'd0;
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'hFFFF_FFFF;
    arm_pulse();
    tick();
    tick();
    tick();
    check("t5_state_wait", 32'(state), 32'd2);
    check("t5_trig_addr_pre", 32'(trig_addr), 32'd22);
    #2;
    rst_n = 1'b0;
    #2;
    check("t5_rst_state", 32'(state), 32'd0);
    check("t5_rst_trig_addr", 32'(trig_addr), 32'd0);
    check("t5_rst_rd_data", rd_data, 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    probe = 32'h300;
    pre_count = 10'd2; post_count = 10'd1;
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'h305;
    arm_pulse();
    wait_done(50, n);
    check("t5_cycles", 32'(n), 32'd6);
    check("t5_trig_addr", 32'(trig_addr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      read_at(i, d);
      check($sformatf("t5_rd%0d", i), d, 32'h303 + 32'(i));
    end

    // Test 6: held pattern 0x55 with mask FF
    auto_inc = 1'b0;
    probe = 32'h55;
    pre_count = 10'd0; post_count = 10'd0;
    trig_mask = 32'hFF; trig_value = 32'h55;
    arm_pulse();
`ifdef LA_EDGE_TRIG_EN
    tick();
    tick();
    tick();
    check("t6_no_trig_state", 32'(state), 32'd2);
    check("t6_no_trig", 32'(triggered), 32'd0);
    probe = 32'h54;
    tick();
    check("t6_step_state", 32'(state), 32'd2);
    probe = 32'h55;
    tick();
    check("t6_edge_state", 32'(state), 32'd4);
    check("t6_edge_trig", 32'(triggered), 32'd1);
    check("t6_trig_addr", 32'(trig_addr), 32'd10);
`else
    tick();
    check("t6_level_state", 32'(state), 32'd4);
    check("t6_level_trig", 32'(triggered), 32'd1);
    check("t6_trig_addr", 32'(trig_addr), 32'd6);
`endif
    read_at(0, d);
    check("t6_rd0", d, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
